// File: rtl/fft_radix2_seq.sv
// fft_radix2_seq: sequential in-place radix-2 DIT FFT, one butterfly per cycle, streaming load/unload
module fft_radix2_seq #(
  parameter int W = 16,
  parameter int LOG2N = 3,
  parameter int SCALE = 1,
  parameter int SM_IO = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_last,
  output logic         busy,
  output logic         ovf
);
  localparam int N = 1 << LOG2N;
  localparam logic signed [W+16:0] RND = (W+17)'(8192);
  localparam logic signed [W+1:0] HI = (W+2)'((1 << (W-1)) - 1);
  localparam logic signed [W+1:0] LO = ~HI;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;
  state_t state_q, state_d;
  logic run, in_fire, out_fire, cdone, sat;
  logic [LOG2N-1:0] n, k, lidx, half, j, a_addr, b_addr;
  logic [LOG2N-2:0] bf;
  logic [2:0] stg;
  logic [4:0] tw;
  logic signed [15:0] wr, wi;
  logic signed [W-1:0] mre [N];
  logic signed [W-1:0] mim [N];
  logic signed [W-1:0] ar, ai, br, bi;
  logic signed [W+16:0] pr, pq;
  logic signed [W+1:0] tr, ti;
  logic [W:0] c0, c1, c2, c3, oc_re, oc_im;
  function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
  // quarter-wave cosine in Q1.14 for angles i*2*pi/64, i = 0..16
  function automatic logic signed [15:0] qc(input logic [4:0] i);
    case (i)
      5'd0:  return 16'sd16384;
      5'd1:  return 16'sd16305;
      5'd2:  return 16'sd16069;
      5'd3:  return 16'sd15679;
      5'd4:  return 16'sd15137;
      5'd5:  return 16'sd14449;
      5'd6:  return 16'sd13623;
      5'd7:  return 16'sd12665;
      5'd8:  return 16'sd11585;
      5'd9:  return 16'sd10394;
      5'd10: return 16'sd9102;
      5'd11: return 16'sd7723;
      5'd12: return 16'sd6270;
      5'd13: return 16'sd4756;
      5'd14: return 16'sd3196;
      5'd15: return 16'sd1606;
      default: return 16'sd0;
    endcase
  endfunction
  function automatic logic [W:0] clip(input logic signed [W+1:0] v);
    logic signed [W+1:0] s;
    s = (SCALE != 0) ? v >>> 1 : v;
    return (s > HI) ? {1'b1, HI[W-1:0]} : (s < LO) ? {1'b1, LO[W-1:0]} : {1'b0, s[W-1:0]};
  endfunction
  function automatic logic [W-1:0] to_tc(input logic [W-1:0] x);
    return (SM_IO != 0 && x[W-1]) ? W'(0) - {1'b0, x[W-2:0]} : x;
  endfunction
  // bit W flags the unrepresentable most-negative value
  function automatic logic [W:0] to_out(input logic [W-1:0] x);
    logic [W-2:0] m;
    m = (W-1)'(0) - x[W-2:0];
    return (SM_IO == 0 || !x[W-1]) ? {1'b0, x} : (x[W-2:0] == '0) ? {1'b1, {W{1'b1}}} : {1'b0, 1'b1, m};
  endfunction
  assign in_ready = run && (state_q == IDLE || state_q == LOAD);
  assign busy = state_q == COMPUTE || state_q == UNLOAD;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cdone = state_q == COMPUTE && stg == 3'(LOG2N-1) && &bf;
  assign half = LOG2N'(1) << stg;
  assign j = LOG2N'(bf) & (half - 1'b1);
  assign a_addr = ((LOG2N'(bf) >> stg) << (stg + 3'd1)) | j;
  assign b_addr = a_addr | half;
  assign tw = 5'(j << (3'(LOG2N-1) - stg)) << (6 - LOG2N);
  assign wr = tw <= 5'd16 ? qc(tw) : -qc(5'(6'd32 - {1'b0, tw}));
  assign wi = tw <= 5'd16 ? -qc(5'd16 - tw) : -qc(tw - 5'd16);
  assign ar = mre[a_addr];
  assign ai = mim[a_addr];
  assign br = mre[b_addr];
  assign bi = mim[b_addr];
  assign pr = (W+17)'(br) * (W+17)'(wr) - (W+17)'(bi) * (W+17)'(wi);
  assign pq = (W+17)'(br) * (W+17)'(wi) + (W+17)'(bi) * (W+17)'(wr);
  assign tr = (W+2)'((pr + RND) >>> 14);
  assign ti = (W+2)'((pq + RND) >>> 14);
  assign c0 = clip((W+2)'(ar) + tr);
  assign c1 = clip((W+2)'(ar) - tr);
  assign c2 = clip((W+2)'(ai) + ti);
  assign c3 = clip((W+2)'(ai) - ti);
  assign sat = c0[W] | c1[W] | c2[W] | c3[W];
  assign lidx = out_valid ? k + 1'b1 : k;
  assign oc_re = to_out(mre[lidx]);
  assign oc_im = to_out(mim[lidx]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_fire ? LOAD : IDLE;
      LOAD:    state_d = (in_fire && n == LOG2N'(N-1)) ? COMPUTE : LOAD;
      COMPUTE: state_d = cdone ? UNLOAD : COMPUTE;
      UNLOAD:  state_d = (out_fire && out_last) ? IDLE : UNLOAD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk)
    if (in_fire) begin
      mre[rev(n)] <= to_tc(in_re);
      mim[rev(n)] <= to_tc(in_im);
    end else if (state_q == COMPUTE) begin
      mre[a_addr] <= c0[W-1:0];
      mre[b_addr] <= c1[W-1:0];
      mim[a_addr] <= c2[W-1:0];
      mim[b_addr] <= c3[W-1:0];
    end
  // output stage is registered: bin 0 is fetched on the first UNLOAD cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      n <= '0;
      bf <= '0;
      stg <= '0;
      k <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      ovf <= 1'b0;
    end else begin
      run <= 1'b1;
      if (in_fire) n <= n + 1'b1;
      if (in_fire && state_q == IDLE) ovf <= 1'b0;
      if (state_q == COMPUTE) begin
        bf <= bf + 1'b1;
        if (&bf) stg <= cdone ? '0 : stg + 3'd1;
        if (sat) ovf <= 1'b1;
      end
      if (state_q == UNLOAD && (!out_valid || out_ready)) begin
        if (out_valid && out_last) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
          out_re <= '0;
          out_im <= '0;
          k <= '0;
        end else begin
          out_valid <= 1'b1;
          out_last <= lidx == LOG2N'(N-1);
          out_re <= oc_re[W-1:0];
          out_im <= oc_im[W-1:0];
          k <= lidx;
          if (oc_re[W] | oc_im[W]) ovf <= 1'b1;
        end
      end
    end
endmodule
